// File: rtl/io_dispatch_pkg.sv
// Shared state encoding and word-counter sizing for the IO dispatcher.
// IO_WORDCNT_EN (in io_dispatch_fsm) enables the per-channel word counters sized here.
package io_dispatch_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      LOADED = 2'd2,
      CALC   = 2'd3
   } state_e;

   localparam int                WCNT_W   = 16;
   localparam logic [WCNT_W-1:0] WCNT_MAX = {WCNT_W{1'b1}};

endpackage

// File: rtl/io_dispatch_fsm_if.sv
// Host/channel/coordinator signal bundle for io_dispatch_fsm.
// The slave modport is the dispatcher's view; master is the surrounding system.
interface io_dispatch_fsm_if
   import io_dispatch_pkg::*;
#(
   parameter int NCH   = 4,
   parameter int DW    = 32,
   parameter int OBJ_W = 2
);
   logic                    cmd_load;
   logic                    cmd_calc;
   logic                    calc_done;
   logic [NCH*OBJ_W-1:0]    cfg_objs;
   logic                    in_valid;
   logic [DW-1:0]           in_data;
   logic                    in_eob;
   logic                    in_ready;
   logic [NCH-1:0]          ch_valid;
   logic [DW-1:0]           ch_data;
   logic                    ch_eob;
   logic [NCH-1:0]          ch_ready;
   logic [NCH-1:0]          ch_start;
   logic [NCH-1:0]          ch_finished;
   logic                    load_done;
   logic                    busy_calc;
   logic [NCH*WCNT_W-1:0]   ch_words;

   modport master (
      output cmd_load, cmd_calc, calc_done, cfg_objs,
      output in_valid, in_data, in_eob, ch_ready,
      input  in_ready, ch_valid, ch_data, ch_eob, ch_start,
      input  ch_finished, load_done, busy_calc, ch_words
   );

   modport slave (
      input  cmd_load, cmd_calc, calc_done, cfg_objs,
      input  in_valid, in_data, in_eob, ch_ready,
      output in_ready, ch_valid, ch_data, ch_eob, ch_start,
      output ch_finished, load_done, busy_calc, ch_words
   );
endinterface

// File: rtl/io_rr_next.sv
// Finds the next unfinished channel cyclically after ptr_i (ptr_i itself last).
// When every channel is finished, next_o holds ptr_i and none_left_o is set.
module io_rr_next #(
   parameter int NCH   = 4,
   parameter int PTR_W = 2
) (
   input  logic [PTR_W-1:0] ptr_i,
   input  logic [NCH-1:0]   fin_i,
   output logic [PTR_W-1:0] next_o,
   output logic             none_left_o
);
   logic found;
   int   idx;

   always_comb begin
      next_o = ptr_i;
      found  = 1'b0;
      idx    = 0;
      for (int k = 1; k <= NCH; k++) begin
         idx = (int'(ptr_i) + k) % NCH;
         if (!found && !fin_i[idx]) begin
            found  = 1'b1;
            next_o = PTR_W'(idx);
         end
      end
      none_left_o = ~found;
   end
endmodule

// File: rtl/io_dispatch_fsm.sv
// Round-robin dispatcher of host words to NCH decompressor channels, plus load/calc sequencing.
// Define IO_WORDCNT_EN to build 16-bit saturating per-channel accepted-word counters.
module io_dispatch_fsm
   import io_dispatch_pkg::*;
#(
   parameter int NCH   = 4,
   parameter int DW    = 32,
   parameter int OBJ_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   io_dispatch_fsm_if.slave bus
);
   localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

   state_e               state_q, state_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [NCH*OBJ_W-1:0] cfg_q, cfg_d;
   logic [NCH-1:0]       fin_q, fin_d;
   logic [NCH-1:0]       start_q, start_d;
   logic                 load_done_q, load_done_d;
   logic [OBJ_W-1:0]     eob_cnt_q [NCH];
   logic [OBJ_W-1:0]     eob_cnt_d [NCH];

   logic [OBJ_W-1:0]     cfg_ch [NCH];
   logic [NCH-1:0]       entry_fin;
   logic [NCH-1:0]       ptr_onehot;
   logic [NCH-1:0]       fin_upd;
   logic [OBJ_W-1:0]     cnt_inc;
   logic                 xfer;
   logic                 eob_hit;
   logic [PTR_W-1:0]     adv_next, entry_next;
   logic                 adv_none, entry_none;

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_cfg
         assign cfg_ch[gi]    = cfg_q[gi*OBJ_W +: OBJ_W];
         assign entry_fin[gi] = (bus.cfg_objs[gi*OBJ_W +: OBJ_W] == '0);
      end
   endgenerate

   assign ptr_onehot = NCH'(1) << ptr_q;

   // Stream is gated only by the selected channel: a stalled channel blocks, never skipped.
   assign bus.in_ready = (state_q == LOAD) & ~fin_q[ptr_q] & bus.ch_ready[ptr_q];
   assign xfer         = bus.in_valid & bus.in_ready;
   assign bus.ch_valid = ((state_q == LOAD) && bus.in_valid && !fin_q[ptr_q]) ? ptr_onehot : '0;
   assign bus.ch_data  = bus.in_data[DW-1:0];
   assign bus.ch_eob   = bus.in_eob;

   assign cnt_inc = eob_cnt_q[ptr_q] + OBJ_W'(1);
   assign eob_hit = xfer & bus.in_eob & (cnt_inc == cfg_ch[ptr_q]);
   assign fin_upd = fin_q | (eob_hit ? ptr_onehot : '0);

   // Pointer advance sees this cycle's finish update so a just-finished channel is skipped.
   io_rr_next #(.NCH(NCH), .PTR_W(PTR_W)) u_adv (
      .ptr_i       (ptr_q),
      .fin_i       (fin_upd),
      .next_o      (adv_next),
      .none_left_o (adv_none)
   );

   // Searching after NCH-1 yields the lowest unfinished channel of the new config.
   io_rr_next #(.NCH(NCH), .PTR_W(PTR_W)) u_entry (
      .ptr_i       (PTR_W'(NCH-1)),
      .fin_i       (entry_fin),
      .next_o      (entry_next),
      .none_left_o (entry_none)
   );

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cfg_d       = cfg_q;
      fin_d       = fin_q;
      start_d     = '0;
      load_done_d = 1'b0;
      for (int i = 0; i < NCH; i++) eob_cnt_d[i] = eob_cnt_q[i];

      case (state_q)
         IDLE: begin
            if (bus.cmd_load) begin
               state_d = LOAD;
               cfg_d   = bus.cfg_objs;
               fin_d   = entry_fin;
               ptr_d   = entry_none ? '0 : entry_next;
               start_d = ~entry_fin;
               for (int i = 0; i < NCH; i++) eob_cnt_d[i] = '0;
            end
         end
         LOAD: begin
            if (&fin_q) begin
               state_d     = LOADED;
               load_done_d = 1'b1;
            end else begin
               if (xfer && bus.in_eob) eob_cnt_d[ptr_q] = cnt_inc;
               fin_d = fin_upd;
               if (xfer && !adv_none) ptr_d = adv_next;
            end
         end
         LOADED: if (bus.cmd_calc)  state_d = CALC;
         CALC:   if (bus.calc_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         cfg_q       <= '0;
         fin_q       <= '0;
         start_q     <= '0;
         load_done_q <= 1'b0;
         for (int i = 0; i < NCH; i++) eob_cnt_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cfg_q       <= cfg_d;
         fin_q       <= fin_d;
         start_q     <= start_d;
         load_done_q <= load_done_d;
         for (int i = 0; i < NCH; i++) eob_cnt_q[i] <= eob_cnt_d[i];
      end
   end

   assign bus.ch_start    = start_q;
   assign bus.ch_finished = fin_q;
   assign bus.load_done   = load_done_q;
   assign bus.busy_calc   = (state_q == CALC);

`ifdef IO_WORDCNT_EN
   logic [WCNT_W-1:0] wcnt_q [NCH];
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_wcnt
         always_ff @(posedge clk) begin
            if (reset || (state_q == IDLE && bus.cmd_load))
               wcnt_q[gi] <= '0;
            else if (xfer && ptr_q == PTR_W'(gi) && wcnt_q[gi] != WCNT_MAX)
               wcnt_q[gi] <= wcnt_q[gi] + WCNT_W'(1);
         end
         assign bus.ch_words[gi*WCNT_W +: WCNT_W] = wcnt_q[gi];
      end
   endgenerate
`else
   assign bus.ch_words = '0;
`endif

endmodule
